// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register with stall, flush and bubble counter.
//
// Captures the decoded instruction from ID into the EX stage on every rising
// clock edge. Update priority on each edge: reset, flush, stall, load.
// A flush, or a load of an instruction that is not valid, inserts a bubble
// (all outputs zero) and bumps a saturating bubble counter.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   stall, flush        pipeline hazard controls
//   id_valid            ID instruction is real
//   id_ex[2:0]          ALU operation class, passed through undecoded
//   id_rs1_data, id_rs2_data, id_imm, id_pc [XLEN-1:0]   operands / imm / PC
//   id_rs1, id_rs2, id_rd [4:0]                          register indices
//   id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src
//   ex_*                registered EX-stage copies of the above
//   bubble_cnt[CNT_W-1:0] saturating count of bubbles issued into EX
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [2:0]       id_ex,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  output logic             ex_valid,
  output logic [2:0]       ex_ex,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_q,      valid_d;
  logic [2:0]       ex_q,         ex_d;
  logic [XLEN-1:0]  rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]  imm_q,        imm_d;
  logic [XLEN-1:0]  pc_q,         pc_d;
  logic [4:0]       rs1_q,        rs1_d;
  logic [4:0]       rs2_q,        rs2_d;
  logic [4:0]       rd_q,         rd_d;
  logic             reg_write_q,  reg_write_d;
  logic             mem_read_q,   mem_read_d;
  logic             mem_write_q,  mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             alu_src_q,    alu_src_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic             load_bubble;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Flush wins over stall; an invalid ID slot becomes a bubble only when
  // the stage is actually advancing.
  assign load_bubble = flush || (!stall && !id_valid);

  always_comb begin
    valid_d      = valid_q;
    ex_d         = ex_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    cnt_d        = cnt_q;
    if (load_bubble) begin
      valid_d      = 1'b0;
      ex_d         = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      pc_d         = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_src_d    = 1'b0;
      cnt_d        = sat_inc(cnt_q);
    end else if (!stall) begin
      valid_d      = 1'b1;
      ex_d         = id_ex;
      rs1_data_d   = id_rs1_data;
      rs2_data_d   = id_rs2_data;
      imm_d        = id_imm;
      pc_d         = id_pc;
      rs1_d        = id_rs1;
      rs2_d        = id_rs2;
      rd_d         = id_rd;
      // Writes to x0 are dropped here so later stages never see them.
      reg_write_d  = id_reg_write && (id_rd != 5'd0);
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
      alu_src_d    = id_alu_src;
    end
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ex_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      ex_q         <= ex_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_ex         = ex_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_pc         = pc_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_alu_src    = alu_src_q;
  assign bubble_cnt    = cnt_q;

endmodule
